// File: rtl/exhaustive_vector_checker.sv
// exhaustive_vector_checker: sweeps every WIDTH-bit input vector into a
// circuit under test and compares its output with a golden model after a
// fixed pipeline latency. Reports pass/fail, the mismatch count and the
// first failing vector.
module exhaustive_vector_checker #(
  parameter int WIDTH        = 3,
  parameter int LATENCY      = 0,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] vec,
  output logic             vec_valid,
  input  logic             dut_f,
  input  logic             gold_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam logic [WIDTH-1:0] VEC_MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] VEC_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ERR_ONE    = {{WIDTH{1'b0}}, 1'b1};
  // DRAIN lasts LATENCY cycles; the counter is loaded with LATENCY-1.
  localparam logic [3:0]       DRAIN_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             vec_valid_q, vec_valid_d;
  logic [WIDTH:0]   err_q, err_d;
  logic [WIDTH-1:0] ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic [3:0]       drain_q, drain_d;

  logic             flush;
  logic             cmp_valid;
  logic [WIDTH-1:0] cmp_vec;
  logic             mis;

  // Compare pipeline: (vec_valid, vec) delayed by LATENCY stages.
  if (LATENCY == 0) begin : g_nopipe
    assign cmp_valid = vec_valid_q;
    assign cmp_vec   = vec_q;
  end else begin : g_pipe
    logic [LATENCY:1]            vld_pipe_q, vld_pipe_d;
    logic [LATENCY:1][WIDTH-1:0] vec_pipe_q, vec_pipe_d;

    // Shift one stage per cycle; a stop-on-fail flush empties every stage.
    always_comb begin
      vld_pipe_d    = vld_pipe_q;
      vec_pipe_d    = vec_pipe_q;
      vld_pipe_d[1] = vec_valid_q;
      vec_pipe_d[1] = vec_q;
      for (int i = 2; i <= LATENCY; i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        vec_pipe_d[i] = vec_pipe_q[i-1];
      end
      if (flush) vld_pipe_d = '0;
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe_q <= '0;
        vec_pipe_q <= '0;
      end else begin
        vld_pipe_q <= vld_pipe_d;
        vec_pipe_q <= vec_pipe_d;
      end
    end

    assign cmp_valid = vld_pipe_q[LATENCY];
    assign cmp_vec   = vec_pipe_q[LATENCY];
  end

  // Outputs are ignored (even X) unless the compare slot is live.
  assign mis = cmp_valid && (dut_f != gold_f);

  // Next-state, stimulus stepping and result capture.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    vec_valid_d = vec_valid_q;
    err_d       = err_q;
    ffv_d       = ffv_q;
    ffvalid_d   = ffvalid_q;
    drain_d     = drain_q;
    flush       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          vec_d       = '0;
          vec_valid_d = 1'b1;
          err_d       = '0;
          ffv_d       = '0;
          ffvalid_d   = 1'b0;
        end
      end
      RUN: begin
        if (vec_q == VEC_MAX) begin
          vec_d       = '0;
          vec_valid_d = 1'b0;
          drain_d     = DRAIN_INIT;
          state_d     = (LATENCY == 0) ? DONE : DRAIN;
        end else begin
          vec_d = vec_q + VEC_ONE;
        end
      end
      DRAIN: begin
        if (drain_q == 4'd0) state_d = DONE;
        else                 drain_d = drain_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // The compare pipeline is empty in IDLE/DONE, so this never collides
    // with the clear done on start.
    if (mis) begin
      err_d = err_q + ERR_ONE;
      if (!ffvalid_q) begin
        ffv_d     = cmp_vec;
        ffvalid_d = 1'b1;
        if (STOP_ON_FAIL) begin
          state_d     = DONE;
          vec_d       = '0;
          vec_valid_d = 1'b0;
          flush       = 1'b1;
        end
      end
    end
  end

  // State and result registers; reset discards any partial sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      err_q       <= '0;
      ffv_q       <= '0;
      ffvalid_q   <= 1'b0;
      drain_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      err_q       <= err_d;
      ffv_q       <= ffv_d;
      ffvalid_q   <= ffvalid_d;
      drain_q     <= drain_d;
    end
  end

  assign vec              = vec_q;
  assign vec_valid        = vec_valid_q;
  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);
  assign pass             = (state_q == DONE) && (err_q == '0);
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: doc/exhaustive_vector_checker.md
# exhaustive_vector_checker

Synthesisable self-checking stimulus engine for small combinational or pipelined circuits under test. On `start` it sweeps every input vector of a parametrised width, from 0 to 2^WIDTH-1. For each vector it compares the circuit's output against a golden-model output, after a parametrised pipeline latency. It reports pass/fail, the mismatch count and the first failing vector, so circuit tests can run in simulation or on the lab board without a behavioural bench.

## Interface
- WIDTH, default 3: number of input bits driven into the circuit under test; legal range 1..16.
- LATENCY, default 0: clock cycles between `vec` being presented and `dut_f`/`gold_f` being valid; legal range 0..15.
- STOP_ON_FAIL, default 0: 1 = abort the sweep on the first mismatch; 0 = complete the full sweep.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a sweep; sampled only in IDLE or DONE.
- vec  out  WIDTH  current stimulus vector to the circuit under test.
- vec_valid  out  1  high while `vec` carries a live stimulus.
- dut_f  in  1  circuit-under-test output.
- gold_f  in  1  golden-model output for the same vector.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; level, not pulse.
- pass  out  1  valid when `done` is high; 1 iff err_count == 0.
- err_count  out  WIDTH+1  number of mismatches in the current or last sweep.
- first_fail_vec  out  WIDTH  vector of the first mismatch.
- first_fail_valid  out  1  `first_fail_vec` holds a captured value.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset values: state=IDLE, vec=0, vec_valid=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0. All compare-pipeline valid bits are cleared.
- IDLE or DONE with start=1:
  - Next state is RUN.
  - vec=0, vec_valid=1.
  - err_count, first_fail_vec and first_fail_valid clear.
  - done=0, pass=0.
- RUN:
  - vec increments by 1 each cycle.
  - In the cycle presenting 2^WIDTH-1, the next state is DRAIN (LATENCY>0) or DONE (LATENCY=0), and vec_valid drops.
  - vec returns to 0 on exit; it never wraps while valid.
- DRAIN: vec_valid=0. Stays for exactly LATENCY cycles, then goes to DONE.
- DONE: done=1, busy=0, pass=(err_count==0). Outputs hold until start or reset.
- Compare pipeline:
  - Delays (vec_valid, vec) by LATENCY stages, giving (cmp_valid, cmp_vec). With LATENCY=0, cmp_* = the current vec_valid/vec.
  - At each rising edge with cmp_valid=1 and dut_f != gold_f:
    - err_count increments. Width WIDTH+1 holds 2^WIDTH, so it cannot overflow.
    - If first_fail_valid=0, capture first_fail_vec=cmp_vec and set first_fail_valid=1.
  - When cmp_valid=0, dut_f and gold_f are ignored, including X values.
- STOP_ON_FAIL=1: the edge that records the first mismatch moves the state to DONE immediately. That edge also drops vec_valid, flushes the compare pipeline and leaves err_count=1.
- start while busy is ignored.
- reset mid-sweep returns every output to its reset value on that edge; no partial results are retained.

## Timing
- Let E0 be the edge that samples start=1 in IDLE or DONE.
- Vector v is presented in the cycle after edge E(v), where E(v) is v edges after E0. It is compared at edge E(v+1+LATENCY).
- done rises after edge E(2^WIDTH+LATENCY): 2^WIDTH+LATENCY cycles after E0. This is 8 cycles for WIDTH=3, LATENCY=0.
- With STOP_ON_FAIL=1, done rises after the edge that detects the first mismatch.
- err_count and first_fail_* update after the comparing edge, with no further delay.
- start held high in DONE restarts a sweep on every entry to DONE (back-to-back sweeps with one DONE cycle between them).

## Test plan
- WIDTH=3, LATENCY=0, gold_f=dut_f=a&b|c:
  - done is high exactly 8 cycles after E0; pass=1, err_count=0, first_fail_valid=0.
  - vec steps 0..7 with vec_valid=1 throughout.
- WIDTH=3, LATENCY=0, dut_f forced wrong only for vec=5: done after 8 cycles, pass=0, err_count=1, first_fail_vec=5, first_fail_valid=1.
- WIDTH=3, LATENCY=0, dut_f=~gold_f for every vector: err_count=8 (4'b1000), first_fail_vec=0.
- WIDTH=4, LATENCY=2, circuit under test and golden model each behind two register stages:
  - done 18 cycles after E0, pass=1.
  - Inject a mismatch only on vector 9: err_count=1, first_fail_vec=9.
- WIDTH=3, STOP_ON_FAIL=1, mismatches at vectors 2 and 6:
  - done after edge E3; err_count=1, first_fail_vec=2.
  - vec_valid is low from edge E3 onward.
- Reset and start handling (WIDTH=3):
  - Assert reset while vec=4: all outputs are at reset values after that edge.
  - Then pulse start: a fresh full sweep completes with pass=1.
  - Pulse start again at vec=3: ignored, and the sweep length is still 8 cycles.
